// File: rtl/rv_pkg.sv
// Shared fetch-stage types: data width, buffer entry layout and fetch FSM states.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  // Pop only when occupied; push at full is allowed only alongside a pop.
  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != CW'(DEPTH)) || do_pop);

  assign o_data  = mem[rd_ptr];
  assign o_count = count_q;

  // Storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word requests, tags responses with their PC, buffers them for decode,
// drops in-flight responses after a redirect and traps misaligned fetch addresses.
module inst_fetch
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pc_en,
  input  logic            i_flush,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  output logic            o_fault,
  output logic [XLEN-1:0] o_fault_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_e    state_q, state_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     inflight;
  logic [CW:0]     total_c;
  logic            req_c;
  logic            grant_c;
  logic            tag_pop;
  logic            buf_push;
  logic            buf_pop;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    buf_in;
  fetch_entry_t    buf_head;

  assign inflight = (CW+1)'(outstanding) + (CW+1)'(buf_count);
  assign grant_c  = req_c && i_imem_gnt;
  assign buf_in   = '{pc: tag_head, instr: i_imem_rdata};
  assign buf_pop  = o_instr_valid && i_instr_ready;

  assign o_imem_req    = req_c;
  assign o_pc_en       = grant_c;
  assign o_imem_addr   = i_pc;
  assign o_instr_valid = (buf_count != '0);
  assign o_instr       = buf_head.instr;
  assign o_instr_pc    = buf_head.pc;
  assign o_fault       = (state_q == FAULT);
  assign o_fault_pc    = fault_pc_q;

  // PC tags of granted requests awaiting their response; its count is the outstanding total.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (grant_c),
    .i_data  (i_pc),
    .i_pop   (tag_pop),
    .o_data  (tag_head),
    .o_count (outstanding)
  );

  // Returned instructions waiting for decode.
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (buf_push),
    .i_data  (buf_in),
    .i_pop   (buf_pop),
    .o_data  (buf_head),
    .o_count (buf_count)
  );

  // FSM state, drop counter and captured fault address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RUN;
      drop_q     <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Next state, request issue and response routing; a flush overrides everything.
  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    fault_pc_d = fault_pc_q;
    req_c      = 1'b0;
    tag_pop    = 1'b0;
    buf_push   = 1'b0;
    total_c    = (CW+1)'(outstanding) + (CW+1)'(drop_q);

    case (state_q)
      RUN: begin
        req_c = i_rst_n && !i_flush && (i_pc[1:0] == 2'b00) && (inflight < (CW+1)'(DEPTH));
        if (i_imem_rvalid && (outstanding != '0)) begin
          tag_pop  = 1'b1;
          buf_push = 1'b1;
        end
        if ((i_pc[1:0] != 2'b00) && (outstanding == '0) && (buf_count == '0)) begin
          state_d    = FAULT;
          fault_pc_d = i_pc;
        end
      end
      DRAIN: begin
        if (drop_q == '0) begin
          state_d = RUN;
        end else if (i_imem_rvalid) begin
          drop_d = drop_q - CW'(1);
          if (drop_q == CW'(1)) begin
            state_d = RUN;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Everything still in flight (tagged or already being dropped) must be discarded.
    if (i_flush) begin
      if (i_imem_rvalid && (total_c != '0)) begin
        total_c = total_c - (CW+1)'(1);
      end
      drop_d     = CW'(total_c);
      state_d    = (total_c != '0) ? DRAIN : RUN;
      fault_pc_d = '0;
      tag_pop    = 1'b0;
      buf_push   = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, async reset sequence, then random traffic vs a queue model.
module tb_inst_fetch;

  localparam int unsigned DEPTH = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic        o_pc_en;
  logic        i_flush;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready;
  logic        o_fault;
  logic [31:0] o_fault_pc;

  int errors = 0;
  int checks = 0;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pc          (i_pc),
    .o_pc_en       (o_pc_en),
    .i_flush       (i_flush),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready),
    .o_fault       (o_fault),
    .o_fault_pc    (o_fault_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] pc;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    bit          rdy;
    bit          fl;
    bit          e_req;
    bit          e_en;
    bit          e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
    bit          e_fault;
    logic [31:0] e_fpc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t tbl[$];

  // Reference model: tags of granted requests, buffered entries, responses still to drop.
  logic [31:0] m_tags[$];
  ent_t        m_buf[$];
  int          m_drop;
  bit          m_fault;
  logic [31:0] m_fault_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit gnt, input bit rv, input logic [31:0] rd,
                       input bit rdy, input bit fl);
    i_pc          = pc;
    i_imem_gnt    = gnt;
    i_imem_rvalid = rv;
    i_imem_rdata  = rd;
    i_instr_ready = rdy;
    i_flush       = fl;
  endtask

  function automatic vec_t v(input logic [31:0] pc, input bit gnt, input bit rv, input logic [31:0] rd,
                             input bit rdy, input bit fl, input bit er, input bit een, input bit ev,
                             input logic [31:0] eipc, input logic [31:0] einstr, input bit ef,
                             input logic [31:0] efpc);
    vec_t r;
    r.pc = pc; r.gnt = gnt; r.rv = rv; r.rdata = rd; r.rdy = rdy; r.fl = fl;
    r.e_req = er; r.e_en = een; r.e_valid = ev; r.e_ipc = eipc; r.e_instr = einstr;
    r.e_fault = ef; r.e_fpc = efpc;
    return r;
  endfunction

  function automatic bit model_req();
    return !m_fault && (m_drop == 0) && !i_flush && (i_pc[1:0] == 2'b00) &&
           ((m_tags.size() + m_buf.size()) < DEPTH);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int   total;
    int   nt;
    int   nb;
    bit   rq;
    ent_t e;
    nt = m_tags.size();
    nb = m_buf.size();
    rq = model_req();
    if (i_flush) begin
      total = nt + m_drop;
      if (i_imem_rvalid && total > 0) total--;
      m_drop = total;
      m_tags.delete();
      m_buf.delete();
      m_fault = 0;
      m_fault_pc = '0;
    end else begin
      if (nb > 0 && i_instr_ready) void'(m_buf.pop_front());
      if (!m_fault) begin
        if (m_drop > 0) begin
          if (i_imem_rvalid) m_drop--;
        end else begin
          if (i_imem_rvalid && nt > 0) begin
            e.pc = m_tags.pop_front();
            e.instr = i_imem_rdata;
            m_buf.push_back(e);
          end
          if (rq && i_imem_gnt) m_tags.push_back(i_pc);
          if (i_pc[1:0] != 2'b00 && nt == 0 && nb == 0) begin
            m_fault = 1;
            m_fault_pc = i_pc;
          end
        end
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    bit          rq;
    int          infl;

    // Reset: aligned PC and a grant offered, yet every output stays quiet.
    i_rst_n = 1'b0;
    drive(32'h8, 1, 0, 0, 1, 0);
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst req", 32'(o_imem_req), 0);
    chk("rst pc_en", 32'(o_pc_en), 0);
    chk("rst valid", 32'(o_instr_valid), 0);
    chk("rst instr", o_instr, 0);
    chk("rst instr_pc", o_instr_pc, 0);
    chk("rst fault", 32'(o_fault), 0);
    chk("rst fault_pc", o_fault_pc, 0);
    chk("rst addr", o_imem_addr, 32'h8);
    drive(32'h8, 0, 0, 0, 1, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Back-to-back fetch with one-cycle responses.
    tbl.push_back(v(32'h00, 1, 0, 0,            1, 0, 1, 1, 0, 0,     0,            0, 0));
    tbl.push_back(v(32'h04, 1, 1, 32'hA0000000, 1, 0, 1, 1, 0, 0,     0,            0, 0));
    tbl.push_back(v(32'h08, 1, 1, 32'hA0000001, 1, 0, 0, 0, 1, 32'h0, 32'hA0000000, 0, 0));
    tbl.push_back(v(32'h08, 1, 0, 0,            1, 0, 1, 1, 1, 32'h4, 32'hA0000001, 0, 0));
    tbl.push_back(v(32'h0C, 0, 1, 32'hA0000002, 1, 0, 1, 0, 0, 0,     0,            0, 0));
    tbl.push_back(v(32'h0C, 0, 0, 0,            1, 0, 1, 0, 1, 32'h8, 32'hA0000002, 0, 0));
    tbl.push_back(v(32'h0C, 0, 0, 0,            1, 0, 1, 0, 0, 0,     0,            0, 0));
    // Backpressure: two grants fill the window, one pop frees one request.
    tbl.push_back(v(32'h10, 1, 0, 0,            0, 0, 1, 1, 0, 0,     0,            0, 0));
    tbl.push_back(v(32'h14, 1, 1, 32'hB0000000, 0, 0, 1, 1, 0, 0,     0,            0, 0));
    tbl.push_back(v(32'h18, 1, 1, 32'hB0000001, 0, 0, 0, 0, 1, 32'h10, 32'hB0000000, 0, 0));
    tbl.push_back(v(32'h18, 1, 0, 0,            0, 0, 0, 0, 1, 32'h10, 32'hB0000000, 0, 0));
    tbl.push_back(v(32'h18, 1, 0, 0,            1, 0, 0, 0, 1, 32'h10, 32'hB0000000, 0, 0));
    tbl.push_back(v(32'h18, 1, 0, 0,            0, 0, 1, 1, 1, 32'h14, 32'hB0000001, 0, 0));
    tbl.push_back(v(32'h1C, 1, 0, 0,            0, 0, 0, 0, 1, 32'h14, 32'hB0000001, 0, 0));
    tbl.push_back(v(32'h1C, 0, 1, 32'hB0000002, 1, 0, 0, 0, 1, 32'h14, 32'hB0000001, 0, 0));
    tbl.push_back(v(32'h1C, 0, 0, 0,            1, 0, 1, 0, 1, 32'h18, 32'hB0000002, 0, 0));
    // Flush with two outstanding: both responses dropped, then fetch resumes at 0x100.
    tbl.push_back(v(32'h20,  1, 0, 0,            1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h24,  1, 0, 0,            1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h100, 1, 0, 0,            1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h100, 1, 1, 32'hC0000000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h100, 1, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h100, 1, 1, 32'hC0000001, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h100, 1, 0, 0,            1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h104, 0, 1, 32'hC0000002, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h104, 0, 0, 0,            1, 0, 1, 0, 1, 32'h100, 32'hC0000002, 0, 0));
    // Flush coinciding with the only response: straight back to RUN, nothing emitted.
    tbl.push_back(v(32'h200, 1, 0, 0,            1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h300, 1, 1, 32'hD0000000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h300, 0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h300, 0, 0, 0,            1, 0, 1, 0, 0, 0, 0, 0, 0));
    // Misaligned PC on an idle fetch unit traps until flushed.
    tbl.push_back(v(32'h06, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(32'h06, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h6));
    tbl.push_back(v(32'h40, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h6));
    tbl.push_back(v(32'h40, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h6));
    tbl.push_back(v(32'h40, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].fl);
      #4;
      chk($sformatf("row%0d req", i), 32'(o_imem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d pc_en", i), 32'(o_pc_en), 32'(tbl[i].e_en));
      chk($sformatf("row%0d addr", i), o_imem_addr, tbl[i].pc);
      chk($sformatf("row%0d valid", i), 32'(o_instr_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d instr_pc", i), o_instr_pc, tbl[i].e_ipc);
        chk($sformatf("row%0d instr", i), o_instr, tbl[i].e_instr);
      end
      chk($sformatf("row%0d fault", i), 32'(o_fault), 32'(tbl[i].e_fault));
      if (tbl[i].e_fault) chk($sformatf("row%0d fault_pc", i), o_fault_pc, tbl[i].e_fpc);
      @(posedge i_clk); #1;
    end

    // Async reset between edges with two buffered entries, then a stray response.
    drive(32'h0, 1, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    drive(32'h4, 1, 1, 32'hE0000000, 0, 0);
    @(posedge i_clk); #1;
    drive(32'h8, 1, 1, 32'hE0000001, 0, 0);
    @(posedge i_clk); #1;
    drive(32'h8, 1, 0, 0, 0, 0);
    #1;
    chk("prerst valid", 32'(o_instr_valid), 1);
    chk("prerst instr_pc", o_instr_pc, 32'h0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("midrst valid", 32'(o_instr_valid), 0);
    chk("midrst instr_pc", o_instr_pc, 0);
    chk("midrst req", 32'(o_imem_req), 0);
    chk("midrst pc_en", 32'(o_pc_en), 0);
    drive(32'h8, 0, 0, 0, 0, 0);
    @(posedge i_clk); #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    drive(32'h8, 0, 1, 32'hEEEEEEEE, 1, 0);
    #4;
    chk("postrst req", 32'(o_imem_req), 1);
    @(posedge i_clk); #1;
    drive(32'h8, 0, 0, 0, 1, 0);
    #1;
    chk("stray valid", 32'(o_instr_valid), 0);
    @(posedge i_clk); #1;

    // Random traffic against the queue model.
    m_tags.delete();
    m_buf.delete();
    m_drop = 0;
    m_fault = 0;
    m_fault_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom();
      infl = m_tags.size() + m_drop;
      drive(($urandom_range(0, 99) < 8) ? {r[31:2], 2'($urandom_range(1, 3))} : {r[31:2], 2'b00},
            $urandom_range(0, 99) < 70,
            (infl > 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5),
            $urandom(),
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3);
      #4;
      rq = model_req();
      chk("rnd req", 32'(o_imem_req), 32'(rq));
      chk("rnd pc_en", 32'(o_pc_en), 32'(rq && i_imem_gnt));
      chk("rnd addr", o_imem_addr, i_pc);
      chk("rnd valid", 32'(o_instr_valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        chk("rnd instr_pc", o_instr_pc, m_buf[0].pc);
        chk("rnd instr", o_instr, m_buf[0].instr);
      end
      chk("rnd fault", 32'(o_fault), 32'(m_fault));
      if (m_fault) chk("rnd fault_pc", o_fault_pc, m_fault_pc);
      @(posedge i_clk);
      model_step();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 2, entries in the instruction buffer and maximum outstanding requests; SHALL be a power of two, at least 2.
REQ-002 i_clk  in  1  the only clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_pc  in  32  fetch address from the PC generator.
REQ-005 o_pc_en  out  1  PC advance enable to the PC generator; high exactly in cycles where a request is granted.
REQ-006 i_flush  in  1  redirect; discards all buffered and in-flight fetches.
REQ-007 o_imem_req / o_imem_addr  out  1/32  instruction memory request and word address (= i_pc).
REQ-008 i_imem_gnt  in  1  memory accepts the request in the same cycle.
REQ-009 i_imem_rvalid / i_imem_rdata  in  1/32  in-order read response, at least 1 cycle after grant.
REQ-010 o_instr_valid / o_instr / o_instr_pc  out  1/32/32  buffered instruction and its fetch address to decode.
REQ-011 i_instr_ready  in  1  decode accepts; transfer when valid and ready are both high.
REQ-012 o_fault / o_fault_pc  out  1/32  misaligned-fetch exception and offending address.

Function
REQ-013 FSM states: RUN, DRAIN, FAULT.
REQ-014 o_imem_req SHALL be high only in RUN, with i_flush low, i_pc[1:0]==0, and outstanding+count < DEPTH.
REQ-015 On grant, i_pc SHALL be pushed into a PC-tag queue and outstanding SHALL increment; o_pc_en = o_imem_req & i_imem_gnt.
REQ-016 On rvalid in RUN, {head tag, rdata} SHALL be written to the buffer and outstanding SHALL decrement. A grant and a response in the same cycle leave outstanding unchanged.
REQ-017 A response written in cycle N SHALL be visible on o_instr_valid in cycle N+1 (1-cycle registered latency).
REQ-018 The buffer SHALL be FIFO-ordered; pop on valid & ready; a simultaneous push and pop at full SHALL be legal and keep count constant.
REQ-019 outstanding+count SHALL never exceed DEPTH, so rvalid can never overflow the buffer.
REQ-020 i_flush in any state SHALL, next cycle: empty the buffer, set drop = outstanding minus any rvalid that same cycle, and clear o_fault. The next state SHALL be DRAIN if drop>0, else RUN. No request SHALL issue in the flush cycle.
REQ-021 In DRAIN each rvalid SHALL be discarded and drop SHALL decrement. At drop==0 the FSM SHALL return to RUN, and requests SHALL resume that cycle.
REQ-022 In RUN with i_pc[1:0]!=0, no request SHALL issue. Once outstanding==0 and count==0, the FSM SHALL enter FAULT with o_fault=1 and o_fault_pc=i_pc, and SHALL hold there until i_flush.
REQ-023 rvalid with outstanding==0 and drop==0 SHALL be ignored. Counters SHALL not wrap.

Reset
REQ-024 While i_rst_n is low: state=RUN, buffer empty, outstanding=0, drop=0, and all outputs 0 (o_imem_addr follows i_pc).
REQ-025 Reset asserted mid-operation SHALL discard all entries and tags immediately; responses after release with outstanding==0 are ignored per REQ-023.

Structure
REQ-026 Shared package rv_pkg SHALL hold XLEN=32, fetch_entry_t {pc, instr}, and the fetch FSM state enum.
REQ-027 Buffer and PC-tag queue SHALL each be an instance of one sub-module, fetch_fifo (parameterised width and DEPTH, with push/pop/flush/count).

Verification
REQ-028 Back-to-back: gnt=1, rvalid 1 cycle after each grant, ready=1, pc 0x0,0x4,0x8 -> o_instr_pc 0x0,0x4,0x8 in order; o_pc_en high once per grant.
REQ-029 Backpressure: ready=0, DEPTH=2 -> exactly 2 grants, then o_imem_req=0. Raising ready for one cycle -> one pop and one new request next cycle.
REQ-030 Flush with 2 outstanding, pc redirected to 0x100 -> next 2 rvalids dropped, o_instr_valid stays 0, then first instruction out has pc 0x100.
REQ-031 Flush in the same cycle as an rvalid with 1 outstanding -> drop=0, FSM returns to RUN directly, no stale instruction emitted.
REQ-032 pc=0x6 after buffer drains -> o_fault=1, o_fault_pc=0x6, no request issued; i_flush -> o_fault=0 next cycle.
REQ-033 Async reset pulse between clock edges with 2 buffered entries -> o_instr_valid=0 immediately; stray rvalid after release is ignored.
